// File: rtl/doc_receiver.sv
// UART receiver that writes printable text and cursor controls into the document RAM port.
// Optional even-parity (8E1) framing is enabled by defining DOC_RECEIVER_PARITY_EN.
module doc_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RsRx,
    input  logic              hold,
    output logic [ADDR_W-1:0] doc_a,
    output logic [7:0]        doc_d,
    output logic              doc_we,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              frame_err,
    output logic [ADDR_W-1:0] cursor
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int ROW_W = ADDR_W - 5;

`ifdef DOC_RECEIVER_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t             state_q, state_d;
    logic               rx_s1_q, rx_s1_d;
    logic               rx_s2_q, rx_s2_d;
    logic               rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
`ifdef DOC_RECEIVER_PARITY_EN
    logic               par_err_q, par_err_d;
`endif
    logic [ADDR_W-1:0]  cursor_q, cursor_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [7:0]         pend_data_q, pend_data_d;
    logic [ADDR_W-1:0]  doc_a_q, doc_a_d;
    logic [7:0]         doc_d_q, doc_d_d;
    logic               doc_we_q, doc_we_d;
    logic               byte_valid_q, byte_valid_d;
    logic [7:0]         byte_data_q, byte_data_d;
    logic               frame_err_q, frame_err_d;

    logic               issue;
    logic               good;
    logic               stop_ok;
    logic [ROW_W-1:0]   row_nx;

    always_comb begin
        rx_s1_d      = RsRx;
        rx_s2_d      = rx_s1_q;
        rx_prev_d    = rx_s2_q;
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
`ifdef DOC_RECEIVER_PARITY_EN
        par_err_d    = par_err_q;
`endif
        cursor_d     = cursor_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        doc_a_d      = doc_a_q;
        doc_d_d      = doc_d_q;
        doc_we_d     = 1'b0;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = frame_err_q;
        good         = 1'b0;
        stop_ok      = 1'b1;
        row_nx       = cursor_q[ADDR_W-1:5] + ROW_W'(1);

        // Drain the pending entry; a new entry loaded below in the same cycle takes its place.
        issue = pend_q & ~hold;
        if (issue) begin
            doc_we_d = 1'b1;
            doc_a_d  = pend_addr_q;
            doc_d_d  = pend_data_q;
            pend_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == CNT_W'(HALF - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef DOC_RECEIVER_PARITY_EN
                        state_d   = S_PARITY;
                        par_err_d = 1'b0;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`ifdef DOC_RECEIVER_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                    if (rx_s2_q != ^shift_q) begin
                        par_err_d   = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
`ifdef DOC_RECEIVER_PARITY_EN
                    stop_ok = ~par_err_q;
`endif
                    if (rx_s2_q) begin
                        state_d = S_IDLE;
                        good    = stop_ok;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                if (rx_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (good) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            if (pend_q && !issue) begin
                // Buffer still occupied: the byte and its cursor effect are discarded.
                frame_err_d = 1'b1;
            end else begin
                case (shift_q)
                    8'h0D: cursor_d = {row_nx, 5'b0};
                    8'h1B: cursor_d = '0;
                    8'h08: begin
                        if (cursor_q != '0) begin
                            cursor_d    = cursor_q - ADDR_W'(1);
                            pend_d      = 1'b1;
                            pend_addr_d = cursor_q - ADDR_W'(1);
                            pend_data_d = 8'h20;
                        end
                    end
                    default: begin
                        if (shift_q >= 8'h20 && shift_q <= 8'h7E) begin
                            pend_d      = 1'b1;
                            pend_addr_d = cursor_q;
                            pend_data_d = shift_q;
                            cursor_d    = cursor_q + ADDR_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
`ifdef DOC_RECEIVER_PARITY_EN
            par_err_q    <= 1'b0;
`endif
            cursor_q     <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            doc_a_q      <= '0;
            doc_d_q      <= '0;
            doc_we_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            rx_prev_q    <= rx_prev_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
`ifdef DOC_RECEIVER_PARITY_EN
            par_err_q    <= par_err_d;
`endif
            cursor_q     <= cursor_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            doc_a_q      <= doc_a_d;
            doc_d_q      <= doc_d_d;
            doc_we_q     <= doc_we_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign doc_a      = doc_a_q;
    assign doc_d      = doc_d_q;
    assign doc_we     = doc_we_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;
    assign cursor     = cursor_q;

endmodule

// File: tb/tb_doc_receiver.sv
// Scoreboard bench for doc_receiver: expected writes and bytes are queued as frames are sent.
module tb_doc_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RsRx = 1'b1;
    logic       hold = 1'b0;
    logic [8:0] doc_a;
    logic [7:0] doc_d;
    logic       doc_we;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic [8:0] cursor;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int bv_cnt = 0;

    logic [16:0] exp_wr[$];
    logic [7:0]  exp_bv[$];
    logic [8:0]  mcur = '0;

    doc_receiver #(.CLKS_PER_BIT(16), .ADDR_W(9)) dut (
        .clk(clk), .rst(rst), .RsRx(RsRx), .hold(hold),
        .doc_a(doc_a), .doc_d(doc_d), .doc_we(doc_we),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_err(frame_err), .cursor(cursor)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (doc_we) begin
                wr_cnt++;
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got a=%0d d=%02h, required no write", doc_a, doc_d);
                end else begin
                    logic [16:0] e;
                    e = exp_wr.pop_front();
                    if ({doc_a, doc_d} !== e) begin
                        n_err++;
                        $display("FAIL write_data: got a=%0d d=%02h, required a=%0d d=%02h",
                                 doc_a, doc_d, e[16:8], e[7:0]);
                    end
                end
            end
            if (byte_valid) begin
                bv_cnt++;
                n_cmp++;
                if (exp_bv.size() == 0) begin
                    n_err++;
                    $display("FAIL byte_unexpected: got %02h, required no byte_valid", byte_data);
                end else begin
                    logic [7:0] eb;
                    eb = exp_bv.pop_front();
                    if (byte_data !== eb) begin
                        n_err++;
                        $display("FAIL byte_data: got %02h, required %02h", byte_data, eb);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RsRx = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            idle(16);
        end
`ifdef DOC_RECEIVER_PARITY_EN
        RsRx = ^b;
        idle(16);
`endif
        RsRx = stop_bit;
        idle(16);
    endtask

    task automatic send_good(input logic [7:0] b);
        logic [3:0] r;
        exp_bv.push_back(b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_wr.push_back({mcur, b});
            mcur = mcur + 9'd1;
        end else if (b == 8'h0D) begin
            r = mcur[8:5] + 4'd1;
            mcur = {r, 5'd0};
        end else if (b == 8'h08) begin
            if (mcur != 9'd0) begin
                mcur = mcur - 9'd1;
                exp_wr.push_back({mcur, 8'h20});
            end
        end else if (b == 8'h1B) begin
            mcur = '0;
        end
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        RsRx = 1'b1;
        hold = 1'b0;
        idle(3);
        exp_wr.delete();
        exp_bv.delete();
        mcur = '0;
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_reset();
        idle(3);
        n_cmp++;
        if ({doc_a, doc_d, doc_we, byte_valid, byte_data, frame_err, cursor} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%0d d=%02h we=%b bv=%b bd=%02h fe=%b cur=%0d, required all 0",
                     doc_a, doc_d, doc_we, byte_valid, byte_data, frame_err, cursor);
        end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_basic();
        int b0, w0;
        b0 = bv_cnt;
        w0 = wr_cnt;
        send_good(8'h41);
        idle(8);
        n_cmp++;
        if (bv_cnt - b0 !== 1) begin
            n_err++;
            $display("FAIL basic_bv_count: got %0d, required 1", bv_cnt - b0);
        end
        n_cmp++;
        if (wr_cnt - w0 !== 1) begin
            n_err++;
            $display("FAIL basic_wr_count: got %0d, required 1", wr_cnt - w0);
        end
        n_cmp++;
        if (cursor !== 9'd1) begin
            n_err++;
            $display("FAIL basic_cursor: got %0d, required 1", cursor);
        end
    endtask

    task automatic test_cursor_wrap();
        int w0;
        send_good(8'h1B);
        send_good(8'h0D);
        for (int i = 0; i < 8; i++) send_good(8'h61 + 8'(i));
        n_cmp++;
        if (cursor !== 9'd40) begin
            n_err++;
            $display("FAIL cursor_40: got %0d, required 40", cursor);
        end
        w0 = wr_cnt;
        send_good(8'h0D);
        idle(8);
        n_cmp++;
        if (cursor !== 9'd64 || wr_cnt !== w0) begin
            n_err++;
            $display("FAIL cr_row: got cursor=%0d writes=%0d, required cursor=64 writes=0", cursor, wr_cnt - w0);
        end
        for (int i = 0; i < 13; i++) send_good(8'h0D);
        for (int i = 0; i < 20; i++) send_good(8'h30 + 8'(i % 10));
        n_cmp++;
        if (cursor !== 9'd500) begin
            n_err++;
            $display("FAIL cursor_500: got %0d, required 500", cursor);
        end
        send_good(8'h0D);
        n_cmp++;
        if (cursor !== 9'd0) begin
            n_err++;
            $display("FAIL cr_wrap: got %0d, required 0", cursor);
        end
        for (int i = 0; i < 15; i++) send_good(8'h0D);
        for (int i = 0; i < 31; i++) send_good(8'h41 + 8'(i % 26));
        n_cmp++;
        if (cursor !== 9'd511) begin
            n_err++;
            $display("FAIL cursor_511: got %0d, required 511", cursor);
        end
        send_good(8'h5A);
        idle(8);
        n_cmp++;
        if (cursor !== 9'd0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL char_wrap: got cursor=%0d pending_expect=%0d, required cursor=0 pending_expect=0",
                     cursor, exp_wr.size());
        end
    endtask

    task automatic test_backspace();
        int w0;
        send_good(8'h1B);
        send_good(8'h41);
        send_good(8'h42);
        send_good(8'h08);
        idle(8);
        n_cmp++;
        if (cursor !== 9'd1) begin
            n_err++;
            $display("FAIL bs_cursor: got %0d, required 1", cursor);
        end
        send_good(8'h08);
        w0 = wr_cnt;
        send_good(8'h08);
        idle(8);
        n_cmp++;
        if (cursor !== 9'd0 || wr_cnt !== w0) begin
            n_err++;
            $display("FAIL bs_at_zero: got cursor=%0d writes=%0d, required cursor=0 writes=0", cursor, wr_cnt - w0);
        end
    endtask

    task automatic test_glitch();
        int b0;
        b0 = bv_cnt;
        RsRx = 1'b0;
        idle(4);
        RsRx = 1'b1;
        idle(48);
        n_cmp++;
        if (bv_cnt !== b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL glitch: got bytes=%0d frame_err=%b, required bytes=0 frame_err=0", bv_cnt - b0, frame_err);
        end
        send_good(8'h47);
        idle(8);
        n_cmp++;
        if (bv_cnt !== b0 + 1) begin
            n_err++;
            $display("FAIL glitch_recover: got bytes=%0d, required 1", bv_cnt - b0);
        end
    endtask

    task automatic test_back_to_back();
        int b0;
        b0 = bv_cnt;
        send_good(8'h31);
        send_good(8'h32);
        send_good(8'h33);
        idle(8);
        n_cmp++;
        if (bv_cnt !== b0 + 3 || cursor !== mcur) begin
            n_err++;
            $display("FAIL back_to_back: got bytes=%0d cursor=%0d, required bytes=3 cursor=%0d",
                     bv_cnt - b0, cursor, mcur);
        end
    endtask

    task automatic test_stop_error();
        int b0;
        b0 = bv_cnt;
        send_frame(8'h55, 1'b0);
        idle(20);
        RsRx = 1'b1;
        idle(32);
        n_cmp++;
        if (bv_cnt !== b0 || frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL stop_error: got bytes=%0d frame_err=%b, required bytes=0 frame_err=1", bv_cnt - b0, frame_err);
        end
        send_good(8'h51);
        idle(8);
        n_cmp++;
        if (bv_cnt !== b0 + 1 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL stop_recover: got bytes=%0d unwritten=%0d, required bytes=1 unwritten=0",
                     bv_cnt - b0, exp_wr.size());
        end
    endtask

    task automatic test_hold();
        int w0;
        w0 = wr_cnt;
        hold = 1'b1;
        send_good(8'h58);
        idle(100);
        n_cmp++;
        if (wr_cnt !== w0) begin
            n_err++;
            $display("FAIL hold_stall: got writes=%0d, required 0", wr_cnt - w0);
        end
        hold = 1'b0;
        idle(4);
        n_cmp++;
        if (wr_cnt !== w0 + 1) begin
            n_err++;
            $display("FAIL hold_release: got writes=%0d, required 1", wr_cnt - w0);
        end
        hold = 1'b1;
        send_good(8'h43);
        exp_bv.push_back(8'h44);
        send_frame(8'h44, 1'b1);
        idle(8);
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_err: got frame_err=%b, required 1", frame_err);
        end
        hold = 1'b0;
        idle(8);
        n_cmp++;
        if (wr_cnt !== w0 + 2 || cursor !== mcur) begin
            n_err++;
            $display("FAIL overrun_drop: got writes=%0d cursor=%0d, required writes=2 cursor=%0d",
                     wr_cnt - w0, cursor, mcur);
        end
    endtask

    task automatic test_rst_mid_frame();
        int b0;
        send_good(8'h4D);
        RsRx = 1'b0;
        idle(40);
        rst = 1'b1;
        RsRx = 1'b1;
        #1;
        n_cmp++;
        if ({doc_a, doc_d, doc_we, byte_valid, byte_data, frame_err, cursor} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_frame: got a=%0d d=%02h we=%b bv=%b bd=%02h fe=%b cur=%0d, required all 0",
                     doc_a, doc_d, doc_we, byte_valid, byte_data, frame_err, cursor);
        end
        idle(3);
        exp_wr.delete();
        exp_bv.delete();
        mcur = '0;
        rst = 1'b0;
        b0 = bv_cnt;
        idle(200);
        n_cmp++;
        if (bv_cnt !== b0 || cursor !== 9'd0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abort: got bytes=%0d cursor=%0d frame_err=%b, required 0 0 0",
                     bv_cnt - b0, cursor, frame_err);
        end
        send_good(8'h41);
        idle(8);
        n_cmp++;
        if (cursor !== 9'd1 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL rst_recover: got cursor=%0d unwritten=%0d, required cursor=1 unwritten=0",
                     cursor, exp_wr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cursor_wrap();
        test_backspace();
        test_glitch();
        test_back_to_back();
        test_stop_error();
        do_reset();
        test_hold();
        test_rst_mid_frame();
        idle(4);
        n_cmp++;
        if (exp_wr.size() != 0 || exp_bv.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got writes=%0d bytes=%0d still expected, required 0 0",
                     exp_wr.size(), exp_bv.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
